seq_detect_1011: RTL
====================

# seq_detect_1011

Serial pattern detector that consumes the 1-bit stream produced by the toggle FSM stage, or any single-bit source, and flags every occurrence of the bit pattern 1011. It sits directly downstream of the toggle FSM. It is a Moore state machine with a qualifying valid strobe, a registered one-cycle match pulse and a saturating match counter. Downstream logic uses the match pulse as an event and reads the counter as a status value.

## Interface
- CNT_W, default 8: width of the match counter (minimum 2).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  qualifies din; a bit is consumed only in cycles where in_valid=1.
- din  input  1  serial data bit, MSB of the pattern first.
- cnt_clr  input  1  synchronous clear of match_count.
- match  output  1  one-cycle pulse: the pattern has just completed.
- match_count  output  CNT_W  number of matches since reset or clear; saturates.
- state_o  output  3  current FSM state encoding, for debug and visibility.

## Operation
- States and encodings: IDLE=0 (no prefix), S1=1 ("1"), S10=2 ("10"), S101=3 ("101"), HIT=4 ("1011").
- Encodings 5–7 are illegal. From any of them, the next state is IDLE and no match is produced.
- When in_valid=0, the state holds and din is ignored.
- Transitions when in_valid=1 (din=1 target / din=0 target):
  - IDLE: S1 / IDLE
  - S1: S1 / S10
  - S10: S101 / IDLE
  - S101: HIT / S10
  - HIT: see Configuration.
- Match pulse:
  - Registered: match <= (in_valid && state==S101 && din==1).
  - match is high for exactly one cycle per completed pattern, even if the FSM then holds in HIT because in_valid=0.
- Match counter:
  - match_count increments by 1 on the same edge that sets match.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr=1 forces match_count to 0 on the next edge. It has priority over a simultaneous increment, so that match is lost from the count.
  - cnt_clr does not affect the FSM state or the match output.
- state_o is the registered state, with no combinational path from the inputs.

## Timing
- Reset values: state IDLE (state_o=0), match=0, match_count=0.
- rst has priority over all other inputs. Asserting rst mid-pattern discards any partial prefix. The first valid bit after reset is evaluated from IDLE.
- Latency: match rises 1 cycle after the clock edge that samples the final '1' with in_valid=1.
- Count timing: match_count shows the new value in the same cycle that match is high.
- Throughput: one bit per cycle. Back-to-back in_valid is fully supported.
- Gaps: in_valid gaps of any length inside a pattern do not break detection.

## Configuration
- OVERLAP_EN defined: overlapping detection.
  - From HIT: din=1 goes to S1; din=0 goes to S10.
  - Result: the suffix "1" or "10" of a completed pattern is reused.
- OVERLAP_EN undefined: non-overlapping detection.
  - From HIT: din=1 goes to S1; din=0 goes to IDLE.
  - Result: no bits of a completed pattern are reused.
- All other behaviour is identical in both builds.

## Structure
- Shared package seq_det_pkg holds:
  - the state typedef (3-bit) and the five state constants;
  - the pattern constant 4'b1011, for documentation and the bench.
- Single module. No sub-module: the FSM, the pulse register and the counter are small enough to stay together.
- The saturating counter could be split out as sat_counter if it is reused elsewhere; that is not required here.

## Test plan
- Reset: hold rst for 2 cycles while driving random din/in_valid -> match=0, match_count=0 and state_o=0 throughout, and for 1 cycle after release.
- Stream 1,0,1,1,0,1,1 with in_valid=1 every cycle:
  - OVERLAP_EN -> 2 match pulses (after bits 4 and 7), match_count=2.
  - Without OVERLAP_EN -> 1 pulse, match_count=1.
- Stream 1,0,1,1 with in_valid=0 inserted for 3 cycles between every bit -> exactly 1 match pulse of width 1, 1 cycle after the last valid bit; no repeat while the FSM holds in HIT.
- Bits 1,0,1, then rst for 1 cycle, then 1 -> no match; state_o=1 (S1).
- CNT_W=2, 5 non-overlapping patterns -> match_count goes 1,2,3,3,3; then cnt_clr=1 coincident with a 6th match -> match pulses but match_count=0.
- Force state to 6 via the bench backdoor, then in_valid=1, din=1 -> next state IDLE, match=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the 1011 serial pattern detector.
//   state_t  : 3-bit FSM state type. The legal encodings are IDLE..HIT (0..4),
//              and 5..7 are illegal.
//   PATTERN  : the detected bit pattern, MSB first.
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // no prefix seen
        ST_S1   = 3'd1,   // "1"
        ST_S10  = 3'd2,   // "10"
        ST_S101 = 3'd3,   // "101"
        ST_HIT  = 3'd4    // "1011" just completed
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detect_1011.sv
// ---------------------------------------------------------------------------
// seq_detect_1011
// Moore-style detector for the serial pattern 1011. It produces a registered
// one-cycle match pulse and a saturating match counter.
//
// Build option: OVERLAP_EN
//   defined   -> overlapping detection. From HIT, a 0 goes to S10.
//   undefined -> non-overlapping detection. From HIT, a 0 goes to IDLE.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   qualifies din; a bit is consumed only when high
//   din          in   serial data bit, pattern MSB first
//   cnt_clr      in   synchronous clear of match_count (wins over increment)
//   match        out  one-cycle pulse; the pattern has just completed
//   match_count  out  CNT_W-bit saturating count of matches
//   state_o      out  registered FSM state encoding
// ---------------------------------------------------------------------------
module seq_detect_1011
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             din,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_match;
    logic [CNT_W-1:0] r_count;
    logic             w_hit_now;

    // The final '1' arrives while the FSM sits in S101.
    assign w_hit_now = in_valid && (r_state == ST_S101) && din;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = din ? ST_S1   : ST_IDLE;
            ST_S1:   if (in_valid) w_state_next = din ? ST_S1   : ST_S10;
            ST_S10:  if (in_valid) w_state_next = din ? ST_S101 : ST_IDLE;
            ST_S101: if (in_valid) w_state_next = din ? ST_HIT  : ST_S10;
`ifdef OVERLAP_EN
            // Reuse the "1" or "10" suffix of the completed pattern.
            ST_HIT:  if (in_valid) w_state_next = din ? ST_S1   : ST_S10;
`else
            // Start afresh; only a new leading '1' counts.
            ST_HIT:  if (in_valid) w_state_next = din ? ST_S1   : ST_IDLE;
`endif
            // Encodings 5..7 return to IDLE on the next edge. This happens
            // whatever in_valid is, so a corrupted state never persists.
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_match <= w_hit_now;
        end
    end

    // The clear has priority, so a match on the same edge is not counted.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_count <= '0;
        end else if (w_hit_now && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign state_o     = r_state;

endmodule
